// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared widths and forwarding-select encodings
package fwd_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_SEL_RF  = 2'b00;
    localparam logic [1:0] FWD_SEL_WB  = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM = 2'b10;

    function automatic logic fwd_sel_active(input logic [1:0] sel);
        return sel != FWD_SEL_RF;
    endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// rtl/fwd_sel_cmp.sv - priority compare of one EX source tag against MEM/WB producers
module fwd_sel_cmp
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] src_i,
    input  logic              mem_valid_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] mem_dst_i,
    input  logic              wb_valid_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_dst_i,
    output logic [1:0]        sel_o
);

    logic mem_hit;
    logic wb_hit;

    // Register 0 is hard-wired, so a write to it never produces forwardable data
    assign mem_hit = mem_valid_i && mem_regwrite_i && (mem_dst_i != '0) && (mem_dst_i == src_i);
    assign wb_hit  = wb_valid_i  && wb_regwrite_i  && (wb_dst_i  != '0) && (wb_dst_i  == src_i);

    always_comb begin
        sel_o = FWD_SEL_RF;
        if (ex_valid_i) begin
            if (mem_hit) begin
                sel_o = FWD_SEL_MEM;
            end else if (wb_hit) begin
                sel_o = FWD_SEL_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - shadow tag pipeline, operand forwarding selects and load-use stall
// Defining FWD_HAZARD_STATS_EN adds stall_cnt_o / fwd_cnt_o event counters.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_dst_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       fwd_cnt_o
`endif
);

    logic              ex_valid_q,    ex_valid_d;
    logic [REG_AW-1:0] ex_rs_q,       ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,       ex_rt_d;
    logic [REG_AW-1:0] ex_dst_q,      ex_dst_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q,  ex_memread_d;

    logic              mem_valid_q,    mem_valid_d;
    logic [REG_AW-1:0] mem_dst_q,      mem_dst_d;
    logic              mem_regwrite_q, mem_regwrite_d;

    logic              wb_valid_q,    wb_valid_d;
    logic [REG_AW-1:0] wb_dst_q,      wb_dst_d;
    logic              wb_regwrite_q, wb_regwrite_d;

    logic              load_use;
    logic              ex_load;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;

    // Only a load still sitting in EX can stall; one bubble later it is in MEM and WB forwarding covers it
    assign load_use = ex_valid_q && ex_memread_q && (ex_dst_q != '0) && id_valid_i &&
                      ((ex_dst_q == id_rs_i) || (ex_dst_q == id_rt_i));

    assign ex_load = id_valid_i && !load_use && !flush_i;

    always_comb begin
        ex_valid_d    = ex_load;
        ex_rs_d       = ex_rs_q;
        ex_rt_d       = ex_rt_q;
        ex_dst_d      = ex_dst_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memread_d  = ex_memread_q;
        if (ex_load) begin
            ex_rs_d       = id_rs_i;
            ex_rt_d       = id_rt_i;
            ex_dst_d      = id_dst_i;
            ex_regwrite_d = id_regwrite_i;
            ex_memread_d  = id_memread_i;
        end
    end

    always_comb begin
        mem_valid_d    = ex_valid_q;
        mem_dst_d      = ex_dst_q;
        mem_regwrite_d = ex_regwrite_q;
        wb_valid_d     = mem_valid_q;
        wb_dst_d       = mem_dst_q;
        wb_regwrite_d  = mem_regwrite_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dst_q       <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_dst_q      <= '0;
            mem_regwrite_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_dst_q       <= '0;
            wb_regwrite_q  <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dst_q       <= ex_dst_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_valid_q    <= mem_valid_d;
            mem_dst_q      <= mem_dst_d;
            mem_regwrite_q <= mem_regwrite_d;
            wb_valid_q     <= wb_valid_d;
            wb_dst_q       <= wb_dst_d;
            wb_regwrite_q  <= wb_regwrite_d;
        end
    end

    fwd_sel_cmp #(
        .REG_AW (REG_AW)
    ) u_cmp_a (
        .ex_valid_i     (ex_valid_q),
        .src_i          (ex_rs_q),
        .mem_valid_i    (mem_valid_q),
        .mem_regwrite_i (mem_regwrite_q),
        .mem_dst_i      (mem_dst_q),
        .wb_valid_i     (wb_valid_q),
        .wb_regwrite_i  (wb_regwrite_q),
        .wb_dst_i       (wb_dst_q),
        .sel_o          (sel_a)
    );

    fwd_sel_cmp #(
        .REG_AW (REG_AW)
    ) u_cmp_b (
        .ex_valid_i     (ex_valid_q),
        .src_i          (ex_rt_q),
        .mem_valid_i    (mem_valid_q),
        .mem_regwrite_i (mem_regwrite_q),
        .mem_dst_i      (mem_dst_q),
        .wb_valid_i     (wb_valid_q),
        .wb_regwrite_i  (wb_regwrite_q),
        .wb_dst_i       (wb_dst_q),
        .sel_o          (sel_b)
    );

    assign fwd_a_sel_o = sel_a;
    assign fwd_b_sel_o = sel_b;
    assign stall_o     = load_use;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q,   fwd_cnt_d;

    // A stall raised during a flush is ignored upstream, so it is not counted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (load_use && !flush_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (fwd_sel_active(sel_a) || fwd_sel_active(sel_b)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - vector table, corner sequences and random run against an issue-history model
module tb_fwd_hazard_ctrl;
    import fwd_pkg::*;

    localparam int AW = REG_AW_DEF;

    typedef struct {
        logic          v;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] dst;
        logic          rw;
        logic          mr;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       fl;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs = '0;
    logic [AW-1:0] id_rt = '0;
    logic [AW-1:0] id_dst = '0;
    logic          id_rw = 1'b0;
    logic          id_mr = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          stall;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   fwd_cnt;
    int unsigned   m_stall_cnt = 0;
    int unsigned   m_fwd_cnt = 0;
`endif

    int errors = 0;
    int checks = 0;

    // hist[0] = instruction in EX, hist[1] = MEM, hist[2] = WB
    instr_t hist[$];
    vec_t   tbl[$];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(
        .REG_AW (AW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_dst_i      (id_dst),
        .id_regwrite_i (id_rw),
        .id_memread_i  (id_mr),
        .flush_i       (flush),
        .fwd_a_sel_o   (fwd_a),
        .fwd_b_sel_o   (fwd_b),
        .stall_o       (stall)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stall_cnt_o   (stall_cnt),
        .fwd_cnt_o     (fwd_cnt)
`endif
    );

    function automatic instr_t mk(input int v, input int rs, input int rt, input int dst,
                                  input int rw, input int mr);
        instr_t i;
        i.v   = (v != 0);
        i.rs  = AW'(rs);
        i.rt  = AW'(rt);
        i.dst = AW'(dst);
        i.rw  = (rw != 0);
        i.mr  = (mr != 0);
        return i;
    endfunction

    function automatic vec_t vec(input instr_t i, input int fl, input int ea, input int eb, input int es);
        vec_t r;
        r.ins = i;
        r.fl  = (fl != 0);
        r.ea  = 2'(ea);
        r.eb  = 2'(eb);
        r.es  = (es != 0);
        return r;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, 0, 0, 0, 0);
    endfunction

    // Newest producer that is still in flight (1 = MEM, 2 = WB) supplies the operand
    function automatic logic [1:0] model_sel(input logic [AW-1:0] src);
        if (!hist[0].v) return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            if (hist[age].v && hist[age].rw && hist[age].dst != 0 && hist[age].dst == src)
                return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        return hist[0].v && hist[0].mr && hist[0].dst != 0 && id_valid &&
               (hist[0].dst == id_rs || hist[0].dst == id_rt);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back(nop());
`ifdef FWD_HAZARD_STATS_EN
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
`endif
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input instr_t i, input logic fl);
        id_valid = i.v;
        id_rs    = i.rs;
        id_rt    = i.rt;
        id_dst   = i.dst;
        id_rw    = i.rw;
        id_mr    = i.mr;
        flush    = fl;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] ea, input logic [1:0] eb, input logic es);
        check({tag, "_sel_a"}, 32'(fwd_a), 32'(ea));
        check({tag, "_sel_b"}, 32'(fwd_b), 32'(eb));
        check({tag, "_stall"}, 32'(stall), 32'(es));
    endtask

    // Advance the model across one rising edge using the inputs currently applied
    task automatic cycle_end();
        instr_t nxt;
        logic   st;
        st  = model_stall();
        nxt = nop();
        if (id_valid && !st && !flush) nxt = mk(1, int'(id_rs), int'(id_rt), int'(id_dst), int'(id_rw), int'(id_mr));
`ifdef FWD_HAZARD_STATS_EN
        if (st && !flush) m_stall_cnt++;
        if (model_sel(hist[0].rs) != 0 || model_sel(hist[0].rt) != 0) m_fwd_cnt++;
`endif
        @(posedge clk);
        hist.push_front(nxt);
        void'(hist.pop_back());
        @(negedge clk);
    endtask

    task automatic apply_vec(input vec_t r, input string tag);
        drive(r.ins, r.fl);
        #1;
        check_outs(tag, r.ea, r.eb, r.es);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(nop(), 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Vectors: {instr v,rs,rt,dst,rw,mr}, flush, expected sel_a, sel_b, stall
        tbl.push_back(vec(mk(1,1,2,3,1,0), 0, 0,0,0));  // add $3,$1,$2
        tbl.push_back(vec(mk(1,3,5,4,1,0), 0, 0,0,0));  // sub $4,$3,$5
        tbl.push_back(vec(nop(),           0, 2,0,0));  // sub in EX: A from MEM
        tbl.push_back(vec(nop(),           0, 0,0,0));
        tbl.push_back(vec(mk(1,1,2,3,1,0), 0, 0,0,0));  // add $3
        tbl.push_back(vec(nop(),           0, 0,0,0));
        tbl.push_back(vec(mk(1,7,3,6,1,0), 0, 0,0,0));  // or $6,$7,$3
        tbl.push_back(vec(nop(),           0, 0,1,0));  // or in EX: B from WB
        tbl.push_back(vec(nop(),           0, 0,0,0));
        tbl.push_back(vec(mk(1,1,2,3,1,0), 0, 0,0,0));  // add $3
        tbl.push_back(vec(mk(1,1,2,3,1,0), 0, 0,0,0));  // add $3
        tbl.push_back(vec(mk(1,3,3,8,1,0), 0, 0,0,0));  // and $8,$3,$3
        tbl.push_back(vec(nop(),           0, 2,2,0));  // newest producer wins
        tbl.push_back(vec(nop(),           0, 0,0,0));
        tbl.push_back(vec(mk(1,1,2,2,1,1), 0, 0,0,0));  // lw $2,0($1)
        tbl.push_back(vec(mk(1,2,2,4,1,0), 0, 0,0,1));  // add $4,$2,$2 stalls
        tbl.push_back(vec(mk(1,2,2,4,1,0), 0, 0,0,0));  // held add, bubble in EX
        tbl.push_back(vec(nop(),           0, 1,1,0));  // add in EX: both from WB
        tbl.push_back(vec(nop(),           0, 0,0,0));
        tbl.push_back(vec(mk(1,1,2,0,1,0), 0, 0,0,0));  // add $0
        tbl.push_back(vec(mk(1,0,0,5,1,0), 0, 0,0,0));  // reader of $0
        tbl.push_back(vec(nop(),           0, 0,0,0));  // no forward of $0
        tbl.push_back(vec(mk(1,1,0,0,1,1), 0, 0,0,0));  // lw $0
        tbl.push_back(vec(mk(1,0,0,6,1,0), 0, 0,0,0));  // reader of $0: no stall
        tbl.push_back(vec(nop(),           0, 0,0,0));
        tbl.push_back(vec(mk(1,1,3,3,1,1), 0, 0,0,0));  // lw $3
        tbl.push_back(vec(mk(1,3,0,7,1,0), 1, 0,0,1));  // dependent + flush
        tbl.push_back(vec(nop(),           0, 0,0,0));  // flushed instr never in EX
        tbl.push_back(vec(nop(),           0, 0,0,0));

        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("reset", 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            apply_vec(tbl[k], $sformatf("vec%0d", k));
            cycle_end();
        end

        // Async reset with a pending MEM forward and a live load-use stall
        apply_vec(vec(mk(1,1,2,3,1,0), 0, 0,0,0), "ar0");
        cycle_end();
        apply_vec(vec(mk(1,3,2,2,1,1), 0, 0,0,0), "ar1");
        cycle_end();
        apply_vec(vec(mk(1,2,2,4,1,0), 0, 2,0,1), "ar2");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("ar_async", 2'b00, 2'b00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_vec(vec(mk(1,3,3,5,1,0), 0, 0,0,0), "ar3");
        cycle_end();
        apply_vec(vec(nop(), 0, 0,0,0), "ar4");
        cycle_end();

        do_reset();
        for (int n = 0; n < 2000; n++) begin
            instr_t ri;
            ri = mk(($urandom_range(0, 99) < 85) ? 1 : 0,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 70) ? 1 : 0, ($urandom_range(0, 99) < 35) ? 1 : 0);
            drive(ri, ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
            #1;
            check_outs($sformatf("rand%0d", n), model_sel(hist[0].rs), model_sel(hist[0].rt), model_stall());
            cycle_end();
        end
`ifdef FWD_HAZARD_STATS_EN
        check("stall_cnt", stall_cnt, 32'(m_stall_cnt));
        check("fwd_cnt", fwd_cnt, 32'(m_fwd_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
